scarv_cop_malu_issue: RTL

Issue and writeback sequencer sitting between the coprocessor decode stage and the multi-precision ALU. Accepts one decoded MALU instruction via a valid/ready handshake, holds its fields stable while driving the MALU's valid input until done, steers each MALU writeback word into the correct CPR of the destination pair, and returns a completion response with an error flag to the CPU side.

---
 rtl/scarv_cop_malu_issue_pkg.sv | 30 +++
 rtl/scarv_cop_malu_issue_steer.sv | 35 +++
 rtl/scarv_cop_malu_issue.sv | 91 +++++++++
 3 files changed

// File: rtl/scarv_cop_malu_issue_pkg.sv
// scarv_cop_malu_issue_pkg: MALU subclass codes, issue FSM encodings and subclass decode helpers
// Shared by scarv_cop_malu_issue and scarv_cop_malu_issue_steer; no ports.
package scarv_cop_malu_issue_pkg;
  localparam logic [4:0] SCLASS_MEQU     = 5'd0;
  localparam logic [4:0] SCLASS_MLTE     = 5'd1;
  localparam logic [4:0] SCLASS_MGTE     = 5'd2;
  localparam logic [4:0] SCLASS_MADD_3   = 5'd3;
  localparam logic [4:0] SCLASS_MADD_2   = 5'd4;
  localparam logic [4:0] SCLASS_MSUB_3   = 5'd5;
  localparam logic [4:0] SCLASS_MSUB_2   = 5'd6;
  localparam logic [4:0] SCLASS_MSLL     = 5'd7;
  localparam logic [4:0] SCLASS_MSLLI    = 5'd8;
  localparam logic [4:0] SCLASS_MSRL     = 5'd9;
  localparam logic [4:0] SCLASS_MSRLI    = 5'd10;
  localparam logic [4:0] SCLASS_MACC_2   = 5'd11;
  localparam logic [4:0] SCLASS_MACC_1   = 5'd12;
  localparam logic [4:0] SCLASS_MMUL_2   = 5'd13;
  localparam logic [4:0] SCLASS_MMUL_3   = 5'd14;
  localparam logic [4:0] SCLASS_MCLMUL_2 = 5'd15;
  localparam logic [4:0] SCLASS_MCLMUL_3 = 5'd16;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;
  function automatic logic is_compare(input logic [4:0] sc);
    return sc == SCLASS_MEQU || sc == SCLASS_MLTE || sc == SCLASS_MGTE;
  endfunction
  function automatic logic is_known_subclass(input logic [4:0] sc);
    return sc <= SCLASS_MCLMUL_3;
  endfunction
endpackage

// File: rtl/scarv_cop_malu_issue_steer.sv
// scarv_cop_malu_issue_steer: combinational CPR write steering and write-count check
// in: in_issue, subclass, rd, wr_cnt, idone, malu_ben, malu_wdata
// out: cpr_wen/cpr_waddr/cpr_ben/cpr_wdata, cnt_inc (a pair write happened), err (bad write count)
module scarv_cop_malu_issue_steer
  import scarv_cop_malu_issue_pkg::*;
(
  input  logic        in_issue,
  input  logic [4:0]  subclass,
  input  logic [3:0]  rd,
  input  logic [1:0]  wr_cnt,
  input  logic        idone,
  input  logic [3:0]  malu_ben,
  input  logic [31:0] malu_wdata,
  output logic        cpr_wen,
  output logic [3:0]  cpr_waddr,
  output logic [3:0]  cpr_ben,
  output logic [31:0] cpr_wdata,
  output logic        cnt_inc,
  output logic        err
);
  logic cmp, attempt, room;
  always_comb begin
    cmp       = is_compare(subclass);
    attempt   = in_issue && !cmp && |malu_ben;
    room      = !wr_cnt[1];
    cnt_inc   = attempt && room;
    cpr_wen   = cnt_inc || (in_issue && cmp && idone);
    cpr_waddr = !cpr_wen ? 4'd0 : cmp ? rd : {rd[3:1], wr_cnt[0]};
    cpr_ben   = !cpr_wen ? 4'd0 : cmp ? 4'hF : malu_ben;
    cpr_wdata = cpr_wen ? malu_wdata : 32'd0;
    // the write landing with idone counts toward the pair total
    err       = in_issue && !cmp && ((attempt && !room) ||
                (idone && ({1'b0, wr_cnt} + {2'b0, cnt_inc}) != 3'd2));
  end
endmodule

// File: rtl/scarv_cop_malu_issue.sv
// scarv_cop_malu_issue: MALU issue/writeback sequencer between coprocessor decode and the MALU
// insn_*: decoded instruction handshake; malu_*: MALU issue and writeback; cpr_*: CPR write port;
// rsp_*: completion response. Optional watchdog: define SCARV_COP_MALU_ISSUE_TIMEOUT_EN.
module scarv_cop_malu_issue
  import scarv_cop_malu_issue_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        insn_valid,
  output logic        insn_ready,
  input  logic [4:0]  insn_subclass,
  input  logic [3:0]  insn_rd,
  input  logic [31:0] insn_imm,
  output logic        malu_ivalid,
  input  logic        malu_idone,
  output logic [4:0]  malu_subclass,
  output logic [31:0] malu_imm,
  input  logic [3:0]  malu_cpr_rd_ben,
  input  logic [31:0] malu_cpr_rd_wdata,
  output logic        cpr_wen,
  output logic [3:0]  cpr_waddr,
  output logic [3:0]  cpr_ben,
  output logic [31:0] cpr_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_err
);
  logic [1:0] state, wr_cnt;
  logic [3:0] rd;
  logic       err, in_issue, accept, cnt_inc, steer_err, timeout;
  assign in_issue    = state == ST_ISSUE;
  assign accept      = state == ST_IDLE && insn_valid;
  assign insn_ready  = state == ST_IDLE;
  assign malu_ivalid = in_issue;
  assign rsp_valid   = state == ST_RESP;
  assign rsp_err     = err;
  scarv_cop_malu_issue_steer u_steer (
    .in_issue   (in_issue),
    .subclass   (malu_subclass),
    .rd         (rd),
    .wr_cnt     (wr_cnt),
    .idone      (malu_idone),
    .malu_ben   (malu_cpr_rd_ben),
    .malu_wdata (malu_cpr_rd_wdata),
    .cpr_wen    (cpr_wen),
    .cpr_waddr  (cpr_waddr),
    .cpr_ben    (cpr_ben),
    .cpr_wdata  (cpr_wdata),
    .cnt_inc    (cnt_inc),
    .err        (steer_err)
  );
`ifdef SCARV_COP_MALU_ISSUE_TIMEOUT_EN
  logic [3:0] timer;
  assign timeout = in_issue && !malu_idone && timer == 4'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge g_clk or negedge g_resetn)
    if (!g_resetn) timer <= 4'd0;
    else timer <= in_issue ? timer + 4'd1 : 4'd0;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = TIMEOUT_CYCLES == 0;
  assign timeout = 1'b0;
`endif
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state         <= ST_IDLE;
      malu_subclass <= 5'd0;
      malu_imm      <= 32'd0;
      rd            <= 4'd0;
      wr_cnt        <= 2'd0;
      err           <= 1'b0;
    end else begin
      if (accept) begin
        malu_subclass <= insn_subclass;
        malu_imm      <= insn_imm;
        rd            <= insn_rd;
        wr_cnt        <= 2'd0;
        // unknown subclasses never reach the MALU
        err           <= !is_known_subclass(insn_subclass);
        state         <= is_known_subclass(insn_subclass) ? ST_ISSUE : ST_RESP;
      end
      if (in_issue) begin
        wr_cnt <= wr_cnt + {1'b0, cnt_inc};
        err    <= err | steer_err | timeout;
        if (malu_idone || timeout) state <= ST_RESP;
      end
      if (state == ST_RESP && rsp_ready) state <= ST_IDLE;
    end
  end
endmodule
